// File: rtl/ec_sign_pkg.sv
// Shared types for the sign-range comparison block: comparison codes and FSM states.
package ec_sign_pkg;

  typedef logic [1:0] cmp_code_t;

  localparam cmp_code_t CMP_LT = 2'd0;
  localparam cmp_code_t CMP_EQ = 2'd1;
  localparam cmp_code_t CMP_GT = 2'd2;

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_e;

endpackage

// File: rtl/ec_mr_digit_cmp.sv
// Sticky MSD-first digit comparator. The code output already includes the digit
// presented this cycle, so a caller can register the final result on the last beat.
module ec_mr_digit_cmp
  import ec_sign_pkg::*;
#(
  parameter int unsigned MR_WIDTH = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [MR_WIDTH-1:0] digit,
  input  logic [MR_WIDTH-1:0] threshold,
  output cmp_code_t           code
);

  cmp_code_t r_code;
  cmp_code_t w_code_next;

  // Only an undecided (EQ) code may change; the first differing digit wins.
  always_comb begin
    w_code_next = r_code;
    if (clear) begin
      w_code_next = CMP_EQ;
    end else if (enable && (r_code == CMP_EQ)) begin
      if (digit > threshold) begin
        w_code_next = CMP_GT;
      end else if (digit < threshold) begin
        w_code_next = CMP_LT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_code <= CMP_EQ;
    end else begin
      r_code <= w_code_next;
    end
  end

  assign code = w_code_next;

endmodule

// File: rtl/ec_sign_range_compare.sv
// Sign-range comparison of a mixed-radix digit stream against positive/negative limits.
// Optional idle-timeout abort is enabled by defining EC_SIGN_CMP_TIMEOUT_EN.
module ec_sign_range_compare
  import ec_sign_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned MR_WIDTH   = 18,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] Y_in,
  input  logic [DATA_WIDTH-1:0] cor_in,
  input  logic                  mr_valid,
  input  logic [MR_WIDTH-1:0]   mr_digit,
  input  logic [MR_WIDTH-1:0]   thr_a,
  input  logic [MR_WIDTH-1:0]   thr_b,
  input  logic                  mr_last,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic [1:0]            sign_out_A,
  output logic [1:0]            sign_out_B,
  output logic [DATA_WIDTH-1:0] Y_out,
  output logic [DATA_WIDTH-1:0] cor_out
);

  localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);

  state_e                r_state;
  state_e                w_state_next;
  logic [CntW-1:0]       r_cnt;
  logic [CntW-1:0]       w_cnt_inc;
  logic [DATA_WIDTH-1:0] r_y;
  logic [DATA_WIDTH-1:0] r_cor;
  logic                  r_done;
  logic                  r_len_err;
  cmp_code_t             r_sign_a;
  cmp_code_t             r_sign_b;
  logic [DATA_WIDTH-1:0] r_y_out;
  logic [DATA_WIDTH-1:0] r_cor_out;

  logic      w_accept_start;
  logic      w_beat;
  logic      w_hit_count;
  logic      w_final_beat;
  logic      w_beat_len_err;
  logic      w_timeout;
  logic      w_complete;
  cmp_code_t w_code_a;
  cmp_code_t w_code_b;

  assign w_accept_start = (r_state == IDLE) && start;
  assign w_beat         = (r_state == COMPARE) && mr_valid;
  assign w_cnt_inc      = r_cnt + CntW'(1);
  assign w_hit_count    = (w_cnt_inc == CntW'(NUM_DIGITS));
  assign w_final_beat   = w_beat && (mr_last || w_hit_count);
  // Reaching the count without mr_last is also a length error.
  assign w_beat_len_err = mr_last ? !w_hit_count : 1'b1;
  assign w_complete     = w_final_beat || w_timeout;

`ifdef EC_SIGN_CMP_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  logic [IdleW-1:0] r_idle;

  assign w_timeout = (r_state == COMPARE) && !mr_valid && (r_idle == IdleW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle <= '0;
    end else if ((r_state != COMPARE) || mr_valid || w_timeout) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IdleW'(1);
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  ec_mr_digit_cmp #(
    .MR_WIDTH (MR_WIDTH)
  ) u_cmp_a (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_accept_start),
    .enable    (w_beat),
    .digit     (mr_digit),
    .threshold (thr_a),
    .code      (w_code_a)
  );

  ec_mr_digit_cmp #(
    .MR_WIDTH (MR_WIDTH)
  ) u_cmp_b (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_accept_start),
    .enable    (w_beat),
    .digit     (mr_digit),
    .threshold (thr_b),
    .code      (w_code_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start)      w_state_next = COMPARE;
      COMPARE: if (w_complete) w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state == COMPARE);
    done       = r_done;
    len_err    = r_len_err;
    sign_out_A = r_sign_a;
    sign_out_B = r_sign_b;
    Y_out      = r_y_out;
    cor_out    = r_cor_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_y       <= '0;
      r_cor     <= '0;
      r_done    <= 1'b0;
      r_len_err <= 1'b0;
      r_sign_a  <= CMP_LT;
      r_sign_b  <= CMP_LT;
      r_y_out   <= '0;
      r_cor_out <= '0;
    end else begin
      r_done <= w_complete;
      if (w_accept_start) begin
        r_cnt <= '0;
        r_y   <= Y_in;
        r_cor <= cor_in;
      end else if (w_beat) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_complete) begin
        r_y_out   <= r_y;
        r_cor_out <= r_cor;
        // A timed-out stream reports EQ so downstream applies no correction.
        r_len_err <= w_timeout ? 1'b1 : w_beat_len_err;
        r_sign_a  <= w_timeout ? CMP_EQ : w_code_a;
        r_sign_b  <= w_timeout ? CMP_EQ : w_code_b;
      end
    end
  end

endmodule
